route_sequencer: RTL
====================

Name: route_sequencer

Overview:
- Route state machine for the train controller. It produces the 4-bit Selector consumed by the sensor Syncronizer and the dwell TIMER that the Syncronizer routes to Y in station states 2–5.
- It consumes the Syncronizer's Y as the "advance" condition, debounces it, and steps the route through states 0–15 with wrap-around.
- It drives the motor/direction controls, a one-cycle step pulse, and a lap counter.

Parameters:
- DEBOUNCE, 4: consecutive enabled cycles Y must be 1 before an advance (minimum 1).
- DWELL, 50000000: cycles spent in a station state (2–5) before TIMER asserts (minimum 1).
- LAPW, 8: width of the lap counter.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST_N  input  1  synchronous, active-low reset, sampled on the rising CLK edge.
- Enable  input  1  run enable; 0 freezes the route.
- Y  input  1  advance condition from the Syncronizer; combinational function of Selector, sensors and TIMER.
- Selector  output  4  current route state 0–15, registered; feeds the Syncronizer.
- TIMER  output  1  registered dwell-expired flag; feeds the Syncronizer.
- Motor  output  1  motor on, registered.
- Direction  output  1  0 = forward (states 0–7), 1 = reverse (states 8–15), registered.
- StepPulse  output  1  one-cycle pulse in the cycle after each advance.
- Laps  output  LAPW  number of completed 15→0 wraps, modulo 2^LAPW.

Behaviour:
- Reset (RST_N=0 at a CLK edge) overrides everything, including mid-debounce and mid-dwell:
  - Selector=0, TIMER=0, Motor=0, Direction=0, StepPulse=0, Laps=0.
  - Internal debounce count=0, dwell count=DWELL-1.
- Timed states are 2, 3, 4, 5. All other states are sensor states.
- Debounce: internal count of consecutive enabled edges with Y=1.
  - Y=0 at an enabled edge clears it.
  - Enable=0 clears it.
- Advance: at an edge with Enable=1, Y=1 and debounce count == DEBOUNCE-1:
  - Selector <= Selector+1, mod 16 (15 wraps to 0).
  - Debounce count <= 0, dwell count <= DWELL-1, TIMER <= 0.
  - StepPulse <= 1; otherwise StepPulse <= 0.
  - Laps <= Laps+1 only on the 15→0 advance; it wraps at 2^LAPW.
- Latency: with Y held at 1 from state entry, the next Selector value is visible DEBOUNCE cycles after entry.
- Dwell, applies only at enabled edges in a timed state that is not advancing:
  - If dwell count == 0, TIMER <= 1 and stays 1 until the state is left.
  - Otherwise the dwell count decrements.
  - TIMER therefore rises DWELL cycles after entry. With Y=TIMER, the state advances DWELL+DEBOUNCE cycles after entry.
- Outside timed states: TIMER=0 and dwell count is held at DWELL-1.
- Enable=0:
  - Selector, TIMER, dwell count and Laps hold.
  - Debounce count clears; StepPulse=0; Motor=0.
  - Resuming continues the dwell from the held count.
- Motor <= Enable AND next state not in 2–5, so the motor stops while dwelling at a station.
- Direction <= next state[3].
- TIMER is 0 in the first cycle of every newly entered state, so a stale expiry never carries over.
- All outputs are registers; there is no combinational path from Y to any output, which avoids a loop through the Syncronizer.

Test Plan:
- Reset check: RST_N=0 for 2 edges while Enable=1, Y=1 → Selector=0, TIMER=0, Motor=0, Laps=0, StepPulse=0; release RST_N → no advance before DEBOUNCE enabled edges.
- Debounce (DEBOUNCE=4, Selector=0): Y high 3 cycles, low 1, then high 4 → Selector stays 0 until the 4th consecutive high; becomes 1 the next cycle with StepPulse=1 for exactly one cycle.
- Dwell (DWELL=3, DEBOUNCE=4): enter state 2 with Y tied to TIMER → TIMER=0 for 3 cycles, 1 from the 4th cycle; Selector=3 seven cycles after entry; TIMER=0 in state 3's first cycle; Motor=0 throughout 2–5.
- Enable freeze: drop Enable for 5 cycles mid-dwell in state 4 at dwell count 1 → Selector, TIMER and dwell count hold, Motor=0; after re-enable TIMER rises 2 cycles later.
- Wrap and laps (DEBOUNCE=1, DWELL=1, Y=1 constant): 16 advances → Selector 15→0; Laps=1; Direction=1 in states 8–15, 0 in 0–7; repeat until Laps wraps 255→0 with LAPW=8.
- Reset mid-operation: assert RST_N=0 in state 11 with debounce count 2 → next cycle Selector=0, Laps=0, debounce cleared; no StepPulse.

Source files
------------

// File: rtl/route_sequencer_if.sv
// Control/status bundle between the route sequencer and the sensor Syncronizer.
// The master side drives Enable and Y. The slave side (the sequencer) drives
// the registered route state and motor controls.
interface route_sequencer_if #(
    parameter int LAPW = 8
);
    logic            Enable;
    logic            Y;
    logic [3:0]      Selector;
    logic            TIMER;
    logic            Motor;
    logic            Direction;
    logic            StepPulse;
    logic [LAPW-1:0] Laps;

    modport master (
        output Enable, Y,
        input  Selector, TIMER, Motor, Direction, StepPulse, Laps
    );

    modport slave (
        input  Enable, Y,
        output Selector, TIMER, Motor, Direction, StepPulse, Laps
    );
endinterface

// File: rtl/route_sequencer.sv
// Route sequencer for the train controller.
// It steps the route through states 0-15 with wrap-around. An advance needs the
// Syncronizer's Y to be held high for DEBOUNCE enabled cycles. In the station
// states 2-5 the block times a dwell and raises TIMER when the dwell expires.
// Every output is a register, so there is no combinational loop through the
// Syncronizer.
module route_sequencer #(
    parameter int DEBOUNCE = 4,
    parameter int DWELL    = 50000000,
    parameter int LAPW     = 8
) (
    input logic             CLK,
    input logic             RST_N,
    route_sequencer_if.slave bus
);
    localparam int DEBW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int DWLW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [DEBW-1:0] DEB_LAST   = DEBW'(DEBOUNCE - 1);
    localparam logic [DEBW-1:0] DEB_ZERO   = {DEBW{1'b0}};
    localparam logic [DEBW-1:0] DEB_ONE    = {{(DEBW-1){1'b0}}, 1'b1};
    localparam logic [DWLW-1:0] DWELL_INIT = DWLW'(DWELL - 1);
    localparam logic [DWLW-1:0] DWELL_ZERO = {DWLW{1'b0}};
    localparam logic [DWLW-1:0] DWELL_ONE  = {{(DWLW-1){1'b0}}, 1'b1};
    localparam logic [LAPW-1:0] LAP_ZERO   = {LAPW{1'b0}};
    localparam logic [LAPW-1:0] LAP_ONE    = {{(LAPW-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        ST_SENSOR0   = 4'd0,  ST_SENSOR1   = 4'd1,
        ST_STATION2  = 4'd2,  ST_STATION3  = 4'd3,
        ST_STATION4  = 4'd4,  ST_STATION5  = 4'd5,
        ST_SENSOR6   = 4'd6,  ST_SENSOR7   = 4'd7,
        ST_SENSOR8   = 4'd8,  ST_SENSOR9   = 4'd9,
        ST_SENSOR10  = 4'd10, ST_SENSOR11  = 4'd11,
        ST_SENSOR12  = 4'd12, ST_SENSOR13  = 4'd13,
        ST_SENSOR14  = 4'd14, ST_SENSOR15  = 4'd15
    } routeStateT;

    routeStateT      stateR,  stateNextS;
    logic [DEBW-1:0] debR,    debNextS;
    logic [DWLW-1:0] dwellR,  dwellNextS;
    logic            timerR,  timerNextS;
    logic            motorR,  motorNextS;
    logic            dirR,    dirNextS;
    logic            stepR,   stepNextS;
    logic [LAPW-1:0] lapsR,   lapsNextS;

    // Station states are the only ones that run the dwell timer and stop the motor.
    function automatic logic isTimed(input routeStateT s);
        return (s >= ST_STATION2) && (s <= ST_STATION5);
    endfunction

    // State register: synchronous active-low reset overrides everything.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            stateR <= ST_SENSOR0;
            debR   <= DEB_ZERO;
            dwellR <= DWELL_INIT;
            timerR <= 1'b0;
            motorR <= 1'b0;
            dirR   <= 1'b0;
            stepR  <= 1'b0;
            lapsR  <= LAP_ZERO;
        end else begin
            stateR <= stateNextS;
            debR   <= debNextS;
            dwellR <= dwellNextS;
            timerR <= timerNextS;
            motorR <= motorNextS;
            dirR   <= dirNextS;
            stepR  <= stepNextS;
            lapsR  <= lapsNextS;
        end
    end

    // Next-state logic: debounce, advance, dwell timing and the motor/direction decode.
    always_comb begin
        stateNextS = stateR;
        debNextS   = debR;
        dwellNextS = dwellR;
        timerNextS = timerR;
        lapsNextS  = lapsR;
        stepNextS  = 1'b0;

        if (!bus.Enable) begin
            // Frozen: only the debounce history is lost; the dwell resumes later.
            debNextS = DEB_ZERO;
        end else if (bus.Y && (debR == DEB_LAST)) begin
            stateNextS = routeStateT'(stateR + 4'd1);
            debNextS   = DEB_ZERO;
            dwellNextS = DWELL_INIT;
            timerNextS = 1'b0;
            stepNextS  = 1'b1;
            if (stateR == ST_SENSOR15) begin
                lapsNextS = lapsR + LAP_ONE;
            end else begin
                lapsNextS = lapsR;
            end
        end else begin
            if (bus.Y) begin
                debNextS = debR + DEB_ONE;
            end else begin
                debNextS = DEB_ZERO;
            end
            if (isTimed(stateR)) begin
                if (dwellR == DWELL_ZERO) begin
                    timerNextS = 1'b1;
                end else begin
                    dwellNextS = dwellR - DWELL_ONE;
                end
            end else begin
                timerNextS = 1'b0;
                dwellNextS = DWELL_INIT;
            end
        end

        motorNextS = bus.Enable & ~isTimed(stateNextS);
        dirNextS   = (stateNextS >= ST_SENSOR8);
    end

    assign bus.Selector  = stateR;
    assign bus.TIMER     = timerR;
    assign bus.Motor     = motorR;
    assign bus.Direction = dirR;
    assign bus.StepPulse = stepR;
    assign bus.Laps      = lapsR;
endmodule
